// File: rtl/vga_pkg.sv
// Shared VGA/menu constants, the pixel-stream sideband bundle and the glyph table.
package vga_pkg;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;
    localparam int RGB_W  = 12;
    localparam int DELAY  = 4;

    localparam logic [RGB_W-1:0] FG_DEFAULT = 12'hFFF;
    localparam logic [RGB_W-1:0] HL_DEFAULT = 12'h00F;

    typedef struct packed {
        logic [10:0]      hcount;
        logic [10:0]      vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
        logic [RGB_W-1:0] rgb;
    } vga_t;

    // Sparse font: unlisted codes render blank.
    function automatic logic [7:0] glyph_row(input logic [6:0] code,
                                             input logic [3:0] line);
        logic [7:0] r;
        r = 8'h00;
        case (code)
            7'h01:   r = 8'hAA;
            7'h02:   r = (line == 4'd0) ? 8'hFF : 8'h00;
            7'h03:   r = 8'h80 >> line[2:0];
            7'h7F:   r = 8'hFF;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/menu_char_render_if.sv
// Character address/code link between the renderer and the menu text tables.
interface menu_char_render_if;

    logic [7:0] char_xy;
    logic [6:0] char_code;

    modport master (output char_xy, input char_code);
    modport slave  (input char_xy, output char_code);

endinterface

// File: rtl/menu_font_rom.sv
// 2048x8 glyph ROM, address {char_code, char_line}, registered output.
module menu_font_rom
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    always_ff @(posedge clk) begin
        if (rst) data <= 8'h00;
        else     data <= glyph_row(addr[10:4], addr[3:0]);
    end

endmodule

// File: rtl/menu_char_render.sv
// Text-box glyph overlay on the VGA stream, 4 clk latency on all outputs.
// MENU_HIGHLIGHT_EN: paints the sel_row background with HL_COLOR.
module menu_char_render
    import vga_pkg::*;
#(
    parameter int               XPOS     = 100,
    parameter int               YPOS     = 50,
    parameter int               COLS     = 16,
    parameter int               ROWS     = 4,
    parameter logic [RGB_W-1:0] FG_COLOR = FG_DEFAULT,
    parameter logic [RGB_W-1:0] HL_COLOR = HL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [10:0]      hcount_in,
    input  logic [10:0]      vcount_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             hblnk_in,
    input  logic             vblnk_in,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic [1:0]       sel_row,
    menu_char_render_if.master txt,
    output logic [10:0]      hcount_out,
    output logic [10:0]      vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic [RGB_W-1:0] rgb_out
);

    localparam logic [10:0] X_LO = 11'(XPOS);
    localparam logic [10:0] X_HI = 11'(XPOS + COLS*CHAR_W - 1);
    localparam logic [10:0] Y_LO = 11'(YPOS);
    localparam logic [10:0] Y_HI = 11'(YPOS + ROWS*CHAR_H - 1);

    logic       in_box;
    logic [6:0] rel_x;
    logic [7:0] rel_y;
    vga_t       vin, s1_v, s2_v, s3_v, o_v;
    logic       s1_in, s2_in, s3_in;
    logic [3:0] s1_line, s2_line;
    logic [2:0] s1_bit, s2_bit, s3_bit;
    logic [7:0] xy_q;
    logic [7:0] font_byte;
    logic [RGB_W-1:0] bg, rgb_next;

    // Bounds are checked on the raw counts so the subtraction never wraps.
    assign in_box = (hcount_in >= X_LO) && (hcount_in <= X_HI) &&
                    (vcount_in >= Y_LO) && (vcount_in <= Y_HI) &&
                    !hblnk_in && !vblnk_in;
    assign rel_x = 7'(hcount_in - X_LO);
    assign rel_y = 8'(vcount_in - Y_LO);

    assign vin = '{hcount: hcount_in, vcount: vcount_in,
                   hsync: hsync_in, vsync: vsync_in,
                   hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

    assign txt.char_xy = xy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= '0;
            s2_v    <= '0;
            s3_v    <= '0;
            s1_in   <= 1'b0;
            s2_in   <= 1'b0;
            s3_in   <= 1'b0;
            s1_line <= '0;
            s2_line <= '0;
            s1_bit  <= '0;
            s2_bit  <= '0;
            s3_bit  <= '0;
            xy_q    <= '0;
        end else begin
            s1_v    <= vin;
            s2_v    <= s1_v;
            s3_v    <= s2_v;
            s1_in   <= in_box;
            s2_in   <= s1_in;
            s3_in   <= s2_in;
            s1_line <= rel_y[3:0];
            s2_line <= s1_line;
            s1_bit  <= rel_x[2:0];
            s2_bit  <= s1_bit;
            s3_bit  <= s2_bit;
            if (in_box) xy_q <= {rel_y[7:4], rel_x[6:3]};
        end
    end

    menu_font_rom u_rom (
        .clk  (clk),
        .rst  (rst),
        .addr ({txt.char_code, s2_line}),
        .data (font_byte)
    );

`ifdef MENU_HIGHLIGHT_EN
    logic s1_hl, s2_hl, s3_hl;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hl <= 1'b0;
            s2_hl <= 1'b0;
            s3_hl <= 1'b0;
        end else begin
            s1_hl <= (rel_y[7:4] == {2'b00, sel_row});
            s2_hl <= s1_hl;
            s3_hl <= s2_hl;
        end
    end

    assign bg = s3_hl ? HL_COLOR : s3_v.rgb;
`else
    logic unused_sel;
    assign unused_sel = ^sel_row;
    assign bg = s3_v.rgb;
`endif

    always_comb begin
        rgb_next = s3_v.rgb;
        if (s3_in) rgb_next = font_byte[3'd7 - s3_bit] ? FG_COLOR : bg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_v <= '0;
        end else begin
            o_v     <= s3_v;
            o_v.rgb <= rgb_next;
        end
    end

    assign hcount_out = o_v.hcount;
    assign vcount_out = o_v.vcount;
    assign hsync_out  = o_v.hsync;
    assign vsync_out  = o_v.vsync;
    assign hblnk_out  = o_v.hblnk;
    assign vblnk_out  = o_v.vblnk;
    assign rgb_out    = o_v.rgb;

endmodule

// File: tb/tb_menu_char_render.sv
// Directed bench for menu_char_render with a registered text-table stub.
module tb_menu_char_render;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 0, vsync_in = 0, hblnk_in = 0, vblnk_in = 0;
    logic [11:0] rgb_in = '0;
    logic [1:0]  sel_row = '0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int errors = 0;
    int checks = 0;

    logic [6:0] tbl [256];

    menu_char_render_if tif();

    menu_char_render dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .sel_row(sel_row),
        .txt(tif),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    // Text table: code valid one clock after the address.
    always @(posedge clk) tif.char_code <= tbl[tif.char_xy];

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input logic [6:0] code);
        for (int i = 0; i < 256; i++) tbl[i] = code;
    endtask

    task automatic pix(input int h, input int v, input logic [11:0] c);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        rgb_in    = c;
    endtask

    task automatic test_reset;
        fill(7'h00);
        rst = 1'b1;
        pix(130, 60, 12'h555);
        hsync_in = 1'b1;
        step(2);
        checks++;
        if ({rgb_out, hcount_out, hsync_out, tif.char_xy} !== '0) begin
            errors++;
            $display("FAIL reset: rgb=%h h=%0d hs=%b xy=%h want all 0",
                     rgb_out, hcount_out, hsync_out, tif.char_xy);
        end
        hsync_in = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_char_xy;
        pix(100, 50, 12'h000);
        step();
        checks++;
        if (tif.char_xy !== 8'h00) begin
            errors++;
            $display("FAIL xy_origin: got %h want 00", tif.char_xy);
        end
        pix(108, 50, 12'h000);
        step();
        checks++;
        if (tif.char_xy !== 8'h01) begin
            errors++;
            $display("FAIL xy_col1: got %h want 01", tif.char_xy);
        end
        pix(227, 113, 12'h000);
        step();
        checks++;
        if (tif.char_xy !== 8'h3F) begin
            errors++;
            $display("FAIL xy_corner: got %h want 3F", tif.char_xy);
        end
        fill(7'h7F);
        pix(228, 113, 12'h456);
        step(4);
        checks++;
        if (tif.char_xy !== 8'h3F) begin
            errors++;
            $display("FAIL xy_hold: got %h want 3F", tif.char_xy);
        end
        checks++;
        if (rgb_out !== 12'h456) begin
            errors++;
            $display("FAIL right_edge: rgb=%h want 456", rgb_out);
        end
    endtask

    task automatic test_passthrough;
        pix(20, 20, 12'h000);
        step(5);
        pix(20, 20, 12'h123);
        hsync_in = 1'b1;
        step();
        pix(21, 20, 12'h000);
        hsync_in = 1'b0;
        step(2);
        checks++;
        if (hsync_out !== 1'b0) begin
            errors++;
            $display("FAIL sync_early: hsync_out=%b want 0", hsync_out);
        end
        step();
        checks++;
        if ({hsync_out, rgb_out, hcount_out} !== {1'b1, 12'h123, 11'd20}) begin
            errors++;
            $display("FAIL sync_lat4: hs=%b rgb=%h h=%0d want 1 123 20",
                     hsync_out, rgb_out, hcount_out);
        end
        step();
        checks++;
        if ({hsync_out, rgb_out} !== {1'b0, 12'h000}) begin
            errors++;
            $display("FAIL sync_after: hs=%b rgb=%h want 0 000",
                     hsync_out, rgb_out);
        end
    endtask

    task automatic test_glyph;
        fill(7'h7F);
        pix(130, 70, 12'h456);
        step(4);
        checks++;
        if (rgb_out !== 12'hFFF) begin
            errors++;
            $display("FAIL solid: rgb=%h want FFF", rgb_out);
        end
        fill(7'h00);
        step(4);
        checks++;
        if (rgb_out !== 12'h456) begin
            errors++;
            $display("FAIL blank: rgb=%h want 456", rgb_out);
        end
        fill(7'h01);
        pix(100, 70, 12'h456);
        step(4);
        checks++;
        if (rgb_out !== 12'hFFF) begin
            errors++;
            $display("FAIL msb_left: rgb=%h want FFF", rgb_out);
        end
        pix(101, 70, 12'h456);
        step(4);
        checks++;
        if (rgb_out !== 12'h456) begin
            errors++;
            $display("FAIL bit_sel: rgb=%h want 456", rgb_out);
        end
        fill(7'h02);
        pix(130, 50, 12'h456);
        step(4);
        checks++;
        if (rgb_out !== 12'hFFF) begin
            errors++;
            $display("FAIL line0: rgb=%h want FFF", rgb_out);
        end
        pix(130, 51, 12'h456);
        step(4);
        checks++;
        if (rgb_out !== 12'h456) begin
            errors++;
            $display("FAIL line1: rgb=%h want 456", rgb_out);
        end
    endtask

    task automatic test_edges;
        fill(7'h7F);
        pix(99, 60, 12'h321);
        step(4);
        checks++;
        if (rgb_out !== 12'h321) begin
            errors++;
            $display("FAIL left_edge: rgb=%h want 321", rgb_out);
        end
        pix(150, 114, 12'h321);
        step(4);
        checks++;
        if (rgb_out !== 12'h321) begin
            errors++;
            $display("FAIL bottom_edge: rgb=%h want 321", rgb_out);
        end
        pix(150, 60, 12'h321);
        hblnk_in = 1'b1;
        step(4);
        checks++;
        if ({rgb_out, hblnk_out} !== {12'h321, 1'b1}) begin
            errors++;
            $display("FAIL blanking: rgb=%h hb=%b want 321 1",
                     rgb_out, hblnk_out);
        end
        hblnk_in = 1'b0;
    endtask

    task automatic test_highlight;
        fill(7'h00);
        sel_row = 2'd2;
        pix(130, 82, 12'h456);
        step(4);
`ifdef MENU_HIGHLIGHT_EN
        checks++;
        if (rgb_out !== 12'h00F) begin
            errors++;
            $display("FAIL hl_row2: rgb=%h want 00F", rgb_out);
        end
`else
        checks++;
        if (rgb_out !== 12'h456) begin
            errors++;
            $display("FAIL nohl_row2: rgb=%h want 456", rgb_out);
        end
`endif
        pix(130, 66, 12'h456);
        step(4);
        checks++;
        if (rgb_out !== 12'h456) begin
            errors++;
            $display("FAIL hl_row1: rgb=%h want 456", rgb_out);
        end
        fill(7'h7F);
        pix(130, 82, 12'h456);
        step(4);
        checks++;
        if (rgb_out !== 12'hFFF) begin
            errors++;
            $display("FAIL hl_fg: rgb=%h want FFF", rgb_out);
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] exp_rgb [12];
        fill(7'h00);
        tbl[8'h00] = 7'h01;
        sel_row = 2'd3;
        for (int i = 0; i < 12; i++) begin
            if (98 + i >= 100 && 98 + i <= 107 && (i % 2) == 0)
                exp_rgb[i] = 12'hFFF;
            else
                exp_rgb[i] = 12'h0A0;
        end
        for (int i = 0; i < 15; i++) begin
            if (i < 12) pix(98 + i, 60, 12'h0A0);
            step();
            if (i >= 3) begin
                checks++;
                if ({rgb_out, hcount_out} !== {exp_rgb[i-3], 11'(95 + i)}) begin
                    errors++;
                    $display("FAIL stream[%0d]: rgb=%h h=%0d want %h %0d",
                             i - 3, rgb_out, hcount_out, exp_rgb[i-3], 95 + i);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        fill(7'h7F);
        pix(140, 60, 12'h456);
        step(4);
        checks++;
        if (rgb_out !== 12'hFFF) begin
            errors++;
            $display("FAIL pre_reset: rgb=%h want FFF", rgb_out);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({rgb_out, hcount_out, tif.char_xy} !== '0) begin
            errors++;
            $display("FAIL mid_reset: rgb=%h h=%0d xy=%h want 0",
                     rgb_out, hcount_out, tif.char_xy);
        end
        step();
        rst = 1'b0;
        step(3);
        checks++;
        if (rgb_out !== 12'h000) begin
            errors++;
            $display("FAIL resume_early: rgb=%h want 000", rgb_out);
        end
        step();
        checks++;
        if ({rgb_out, hcount_out} !== {12'hFFF, 11'd140}) begin
            errors++;
            $display("FAIL resume: rgb=%h h=%0d want FFF 140",
                     rgb_out, hcount_out);
        end
    endtask

    initial begin
        test_reset();
        test_char_xy();
        test_passthrough();
        test_glyph();
        test_edges();
        test_highlight();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/menu_char_render.md
# menu_char_render

Pixel-stream consumer of the menu text interface: walks the VGA timing stream, converts screen position inside a fixed text box into a character address `char_xy`, accepts the returned `char_code`, fetches the 8×16 glyph row and overlays foreground pixels on the incoming RGB. It sits in the menu draw chain between the background/rect stage and the VGA output register, and is the address-issuing end of the `char_xy`/`char_code` interface served by the menu text tables.

## Interface
- `XPOS`, 100: left edge of text box, pixels
- `YPOS`, 50: top edge of text box, pixels
- `COLS`, 16: characters per row; fixed at 16 (column field = `char_xy[3:0]`)
- `ROWS`, 4: text rows; max 16 (row field = `char_xy[7:4]`)
- `FG_COLOR`, 12'hFFF: glyph pixel colour
- `HL_COLOR`, 12'h00F: highlight background colour

- `clk` in 1: pixel clock
- `rst` in 1: synchronous, active-high reset
- `hcount_in`, `vcount_in` in 11 each: pixel position
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in` in 1 each: timing
- `rgb_in` in 12: upstream colour
- `sel_row` in 2: selected menu row (used only with highlight)
- `char_code` in 7: character code, valid 1 clk after `char_xy`
- `char_xy` out 8: {row[3:0], col[3:0]} address to text table
- `hcount_out`, `vcount_out`, `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out` out: timing delayed 4 clk
- `rgb_out` out 12: composited colour

## Operation
- Box: x ∈ [XPOS, XPOS+COLS·8−1], y ∈ [YPOS, YPOS+ROWS·16−1]; `in_box` also requires `hblnk_in=0` and `vblnk_in=0`.
- rel_x = hcount_in−XPOS, rel_y = vcount_in−YPOS (11-bit; compare before subtract, no wrap).
- col = rel_x[6:3], row = rel_y[7:4], char_line = rel_y[3:0], bit_sel = rel_x[2:0].
- `char_xy` = {row, col} when in_box; otherwise holds last value (not driven to unknown).
- Glyph row byte from font ROM addressed {char_code, char_line} (11 bits). Pixel = byte[7−bit_sel] (MSB leftmost).
- Composite: in_box & pixel → FG_COLOR; in_box & !pixel → rgb (or HL_COLOR if highlighted); !in_box → rgb_in unchanged.
- Blanking intervals never draw; `rgb_in` passes through delayed.

## Timing
- Stage 1 (clk 1): register `char_xy`, char_line, bit_sel, in_box, row, timing, rgb.
- Stage 2 (clk 2): text table returns registered `char_code`; sidebands delayed.
- Stage 3 (clk 3): font ROM registered output byte; sidebands delayed.
- Stage 4 (clk 4): output register for rgb and all timing outputs.
- Total latency 4 clk for every output; timing/rgb pairs stay aligned.
- Reset: all outputs, `char_xy` and pipeline regs → 0 on the clk after `rst` high; first valid output 4 clk after `rst` low. Reset mid-line: no partial glyph; stream resumes aligned.
- Box edge: pixel at XPOS+COLS·8 is outside on the same cycle boundary as input; no glyph spill.

## Configuration
- `MENU_HIGHLIGHT_EN` defined: in_box pixels of row == `sel_row` with glyph bit 0 output HL_COLOR; glyph bits 1 stay FG_COLOR. `sel_row` sampled in stage 1 and delayed with the row.
- Not defined: `sel_row` ignored (port remains, unconnected internally); background is `rgb_in`.

## Structure
- `vga_pkg`: char width/height constants (8, 16), RGB width, `FG_COLOR`/`HL_COLOR` defaults, timing delay depth (4).
- Sub-module `menu_font_rom`: 2048×8 glyph ROM, registered output, addr {char_code, char_line}.
- Delay registers for sidebands inside this module.

## Test plan
- XPOS=100, YPOS=50; hcount=100, vcount=50 → `char_xy`=8'h00 1 clk later; hcount=108 → 8'h01.
- hcount=227, vcount=113 → `char_xy`=8'h3F; hcount=228 same line → out of box, `rgb_out`=`rgb_in`.
- Outside box, `rgb_in`=12'h123, hsync pulse → both appear unchanged exactly 4 clk later.
- Inside box, stubbed `char_code` of solid glyph (all 8'hFF) → `rgb_out`=12'hFFF; blank glyph → `rgb_in`.
- `MENU_HIGHLIGHT_EN`, `sel_row`=2, blank glyph at vcount=82 → `rgb_out`=12'h00F; row 1 → `rgb_in`.
- Assert `rst` mid-box for 2 clk → all outputs 0 next clk; release → correct output resumes 4 clk later.
